// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display reads win the single RAM port, queued application
// writes fill the back buffer, and front/back swap only on a drained frame boundary.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        disp_valid,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  input  logic                        swap_req,
  output logic                        swap_pending,
  output logic                        front_sel,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ADDR_W:0]             mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] fifo_addr_reg [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  count_reg, count_next;

  logic              front_sel_reg;
  logic              rd_pend_reg;
  logic              disp_valid_reg;
  logic [DATA_W-1:0] disp_data_reg;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic swap_now;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == LVL_W'(FIFO_DEPTH));

  // The display owns the port whenever it asks; writes only use idle slots.
  assign pop    = !disp_req && !fifo_empty;
  assign wr_ack = wr_req && (!fifo_full || pop) && (state_reg != DRAIN);
  assign push   = wr_ack;

  assign swap_pending = (state_reg != IDLE);
  assign front_sel    = front_sel_reg;
  assign fifo_level   = count_reg;
  assign disp_valid   = disp_valid_reg;
  assign disp_data    = disp_data_reg;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (disp_req) begin
      mem_addr = {front_sel_reg, disp_addr};
    end else if (!fifo_empty) begin
      // Back-buffer target is taken at pop time, so a write queued before a swap
      // still lands in whichever half is hidden when it commits.
      mem_addr  = {~front_sel_reg, fifo_addr_reg[rd_ptr_reg]};
      mem_wdata = fifo_data_reg[rd_ptr_reg];
      mem_we    = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + LVL_W'(1);
      2'b01:   count_next = count_reg - LVL_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_reg[wr_ptr_reg] <= wr_addr;
      fifo_data_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    swap_now   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (swap_req) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          if (fifo_empty && !pop) begin
            swap_now   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count_reg == '0) begin
          swap_now   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      front_sel_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (swap_now) begin
        front_sel_reg <= ~front_sel_reg;
      end
    end
  end

  // RAM returns data one cycle after the address; one more register gives N+2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend_reg    <= 1'b0;
      disp_valid_reg <= 1'b0;
      disp_data_reg  <= '0;
    end else begin
      rd_pend_reg    <= disp_req;
      disp_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) begin
        disp_data_reg <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a registered-read RAM model on the memory port.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic [23:0] disp_data;
  logic        disp_valid;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_ack;
  logic        swap_req;
  logic        swap_pending;
  logic        front_sel;
  logic [2:0]  fifo_level;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic [23:0] mem_rdata;

  logic [23:0] ram [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  vga_fb_arbiter #(.ADDR_W(15), .DATA_W(24), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_sel    (front_sel),
    .fifo_level   (fifo_level),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    mem_rdata = '0;
    for (int a = 0; a < 65536; a++) ram[a] = '0;
    ram[16'h0010] = 24'h123456;
    ram[16'h0011] = 24'h654321;
    ram[16'h8010] = 24'hABCDEF;

    repeat (3) tick();
    check_eq("rst_front_sel", front_sel, 1'b0);
    check_eq("rst_fifo_level", fifo_level, 3'd0);
    check_eq("rst_swap_pending", swap_pending, 1'b0);
    check_eq("rst_disp_valid", disp_valid, 1'b0);
    check_eq("rst_disp_data", disp_data, 24'h0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    reset = 1'b1;

    // Single display read: N -> address, N+2 -> data.
    tick(); disp_req = 1'b1; disp_addr = 15'h0010; #1;
    check_eq("rd_mem_addr", mem_addr, 16'h0010);
    check_eq("rd_mem_we", mem_we, 1'b0);
    tick(); disp_req = 1'b0; #1;
    check_eq("rd_valid_n1", disp_valid, 1'b0);
    tick();
    check_eq("rd_valid_n2", disp_valid, 1'b1);
    check_eq("rd_data_n2", disp_data, 24'h123456);
    tick();
    check_eq("rd_valid_n3", disp_valid, 1'b0);

    // Back-to-back reads produce one result per cycle.
    tick(); disp_req = 1'b1; disp_addr = 15'h0010;
    tick(); disp_addr = 15'h0011;
    tick(); disp_req = 1'b0; #1;
    check_eq("b2b_valid0", disp_valid, 1'b1);
    check_eq("b2b_data0", disp_data, 24'h123456);
    tick();
    check_eq("b2b_valid1", disp_valid, 1'b1);
    check_eq("b2b_data1", disp_data, 24'h654321);
    tick();
    check_eq("b2b_valid2", disp_valid, 1'b0);

    // Four writes with the port free: each commits to the back buffer a cycle later.
    for (int i = 0; i <= 4; i++) begin
      tick();
      wr_req  = (i < 4);
      wr_addr = 15'(32'h100 + i);
      wr_data = 24'(32'hA0A0A0 + i);
      #1;
      if (i < 4) check_eq("wr4_ack", wr_ack, 1'b1);
      check_eq("wr4_mem_we", mem_we, (i > 0));
      if (i > 0) begin
        check_eq("wr4_mem_addr", mem_addr, 32'h8100 + i - 1);
        check_eq("wr4_mem_wdata", mem_wdata, 32'hA0A0A0 + i - 1);
      end
    end
    tick(); #1;
    check_eq("wr4_level_end", fifo_level, 3'd0);
    check_eq("wr4_we_end", mem_we, 1'b0);
    check_eq("wr4_ram_8103", ram[16'h8103], 24'hA0A0A3);

    // Display holds the port: queue fills to four, then drains when released.
    for (int i = 0; i < 6; i++) begin
      tick();
      disp_req = 1'b1; disp_addr = '0;
      wr_req   = 1'b1;
      wr_addr  = 15'(32'h200 + ((i < 4) ? i : 4));
      wr_data  = 24'(32'hB00000 + ((i < 4) ? i : 4));
      #1;
      check_eq("full_ack", wr_ack, (i < 4));
      check_eq("full_mem_we", mem_we, 1'b0);
      if (i >= 4) check_eq("full_level", fifo_level, 3'd4);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      disp_req = 1'b0;
      wr_req   = (k == 0);
      #1;
      if (k == 0) begin
        check_eq("drain_level_full", fifo_level, 3'd4);
        check_eq("drain_pending_ack", wr_ack, 1'b1);
      end
      check_eq("drain_mem_we", mem_we, 1'b1);
      check_eq("drain_mem_addr", mem_addr, 32'h8200 + k);
      check_eq("drain_mem_wdata", mem_wdata, 32'hB00000 + k);
    end
    tick(); #1;
    check_eq("drain_level_end", fifo_level, 3'd0);

    // Swap with an empty queue.
    tick(); swap_req = 1'b1; #1;
    check_eq("swp_pending_idle", swap_pending, 1'b0);
    tick(); swap_req = 1'b0; #1;
    check_eq("swp_pending_set", swap_pending, 1'b1);
    check_eq("swp_front_hold", front_sel, 1'b0);
    tick(); frame_start = 1'b1; #1;
    check_eq("swp_pending_fs", swap_pending, 1'b1);
    check_eq("swp_front_fs", front_sel, 1'b0);
    tick(); frame_start = 1'b0; #1;
    check_eq("swp_front_new", front_sel, 1'b1);
    check_eq("swp_pending_clr", swap_pending, 1'b0);
    tick(); wr_req = 1'b1; wr_addr = 15'h0300; wr_data = 24'h111111; #1;
    check_eq("swp_wr_ack", wr_ack, 1'b1);
    tick(); wr_req = 1'b0; #1;
    check_eq("swp_wr_we", mem_we, 1'b1);
    check_eq("swp_wr_addr", mem_addr, 16'h0300);
    tick(); disp_req = 1'b1; disp_addr = 15'h0010; frame_start = 1'b1; #1;
    check_eq("swp_rd_addr", mem_addr, 16'h8010);
    tick(); disp_req = 1'b0; frame_start = 1'b0; #1;
    check_eq("idle_fs_front", front_sel, 1'b1);
    check_eq("idle_fs_pending", swap_pending, 1'b0);
    tick();
    check_eq("swp_rd_data", disp_data, 24'hABCDEF);

    // Swap with three writes queued and display busy during the drain.
    tick(); swap_req = 1'b1; disp_req = 1'b1; disp_addr = '0;
    wr_req = 1'b1; wr_addr = 15'h0400; wr_data = 24'hC00000; #1;
    check_eq("dr_fill_ack", wr_ack, 1'b1);
    tick(); swap_req = 1'b0; wr_addr = 15'h0401; wr_data = 24'hC00001; #1;
    check_eq("dr_pending", swap_pending, 1'b1);
    tick(); wr_addr = 15'h0402; wr_data = 24'hC00002;
    tick(); wr_req = 1'b0; frame_start = 1'b1; #1;
    check_eq("dr_level3", fifo_level, 3'd3);
    for (int d = 0; d < 2; d++) begin
      tick(); frame_start = 1'b0; disp_req = 1'b1;
      wr_req = 1'b1; wr_addr = 15'h0500; wr_data = 24'hD00000; #1;
      check_eq("dr_busy_ack", wr_ack, 1'b0);
      check_eq("dr_busy_we", mem_we, 1'b0);
      check_eq("dr_busy_front", front_sel, 1'b1);
      check_eq("dr_busy_pending", swap_pending, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); disp_req = 1'b0; #1;
      check_eq("dr_pop_ack", wr_ack, 1'b0);
      check_eq("dr_pop_we", mem_we, 1'b1);
      check_eq("dr_pop_addr", mem_addr, 32'h0400 + k);
      check_eq("dr_pop_front", front_sel, 1'b1);
    end
    tick(); #1;
    check_eq("dr_empty_level", fifo_level, 3'd0);
    check_eq("dr_empty_front", front_sel, 1'b1);
    check_eq("dr_empty_ack", wr_ack, 1'b0);
    check_eq("dr_empty_pending", swap_pending, 1'b1);
    tick(); #1;
    check_eq("dr_done_front", front_sel, 1'b0);
    check_eq("dr_done_pending", swap_pending, 1'b0);
    check_eq("dr_done_ack", wr_ack, 1'b1);
    tick(); wr_req = 1'b0; #1;
    check_eq("dr_post_we", mem_we, 1'b1);
    check_eq("dr_post_addr", mem_addr, 16'h8500);

    // Get front_sel back to 1 so the mid-operation reset has something to clear.
    tick(); swap_req = 1'b1;
    tick(); swap_req = 1'b0; frame_start = 1'b1;
    tick(); frame_start = 1'b0; #1;
    check_eq("pre_rst_front", front_sel, 1'b1);

    tick(); disp_req = 1'b1; disp_addr = 15'h0010;
    wr_req = 1'b1; wr_addr = 15'h0600; wr_data = 24'hE00000;
    tick(); wr_addr = 15'h0601; wr_data = 24'hE00001;
    tick(); wr_req = 1'b0; #1;
    check_eq("pre_rst_level", fifo_level, 3'd2);
    reset = 1'b0;
    tick();
    check_eq("mid_rst_valid", disp_valid, 1'b0);
    check_eq("mid_rst_level", fifo_level, 3'd0);
    check_eq("mid_rst_front", front_sel, 1'b0);
    check_eq("mid_rst_pending", swap_pending, 1'b0);
    disp_req = 1'b0; #1;
    check_eq("mid_rst_we", mem_we, 1'b0);
    reset = 1'b1;
    tick();
    check_eq("post_rst_valid", disp_valid, 1'b0);
    check_eq("post_rst_we", mem_we, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA scan-out path (display reads) and the application (pixel writes).
- Implements double buffering: the display reads the front half of the RAM and writes go to the back half.
- Front/back swap occurs only on a frame boundary, after all queued writes have drained.
- Runs in the divided pixel-clock domain, between the application and the painter.

Parameters:
ADDR_W, 15, pixel address width within one buffer (RAM address is ADDR_W+1 bits)
DATA_W, 24, pixel colour width (8 bits each of R, G, B)
FIFO_DEPTH, 4, write-queue entries (power of 2, minimum 2)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse at the start of vertical blanking
disp_req  in  1  display read request this cycle
disp_addr  in  ADDR_W  display pixel address
disp_data  out  DATA_W  read data, registered
disp_valid  out  1  disp_data valid
wr_req  in  1  application write request
wr_addr  in  ADDR_W  write pixel address
wr_data  in  DATA_W  write pixel colour
wr_ack  out  1  write accepted into queue this cycle (combinational)
swap_req  in  1  request a buffer swap (pulse or level)
swap_pending  out  1  swap requested but not yet performed
front_sel  out  1  buffer currently displayed
fifo_level  out  clog2(FIFO_DEPTH)+1  queued write count
mem_addr  out  ADDR_W+1  RAM address, MSB selects the buffer
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address

Behaviour:
- Reset: reset==0 at a clk edge resets the block.
  - front_sel=0, FIFO empty, fifo_level=0, swap FSM in IDLE, swap_pending=0.
  - disp_valid=0, disp_data=0, read pipeline flushed.
  - Reset asserted mid-operation discards queued writes and suppresses any in-flight disp_valid.
- RAM port drive is combinational, with strict display priority:
  - disp_req=1: mem_addr={front_sel,disp_addr}, mem_we=0.
  - else if FIFO not empty: pop head; mem_addr={~front_sel,head.addr}, mem_wdata=head.data, mem_we=1.
  - else: mem_addr=0, mem_we=0, mem_wdata=0.
- Read latency: disp_req at cycle N gives disp_valid=1 and disp_data=mem_rdata in cycle N+2. Back-to-back requests give one result per cycle.
- Write queue:
  - wr_ack = wr_req && fifo_can_accept && state!=DRAIN.
  - fifo_can_accept = not full, or a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Order is preserved; pointers wrap modulo FIFO_DEPTH.
  - Writes stall while disp_req=1. There is no fairness mechanism; blanking provides the drain slots.
- The back-buffer target is evaluated at pop time. No write ever reaches the front buffer.
- Swap FSM (IDLE, PENDING, DRAIN):
  - IDLE: swap_req=1 -> PENDING.
  - PENDING: swap_req ignored. On frame_start:
    - FIFO empty and no pop this cycle -> toggle front_sel, go to IDLE.
    - otherwise -> DRAIN.
  - DRAIN: wr_ack forced to 0. When fifo_level==0 -> toggle front_sel, go to IDLE.
  - swap_pending=1 in PENDING and DRAIN.
  - front_sel toggles at most once per swap request, and only on or after a frame_start.
  - A frame_start seen in IDLE or DRAIN has no effect.
- The front_sel toggle takes effect on the next cycle's read address. A read issued before the toggle returns old-buffer data.
- Any disp_req arriving while the FSM is in DRAIN still takes priority over writes, so draining may extend beyond one cycle.

Test Plan:
- Reset, then disp_req=1 with disp_addr=0x0010 at cycle 5 -> mem_addr=0x0010, mem_we=0; disp_valid=1 at cycle 7 with disp_data equal to mem_rdata from cycle 6.
- disp_req=0, four writes (0x100..0x103, data 0xA0A0A0..) -> wr_ack=1 each; mem_we pulses with mem_addr=0x8100..0x8103 in order; fifo_level returns to 0.
- disp_req held at 1, six writes attempted -> four acked, fifo_level=4, wr_ack=0 for the 5th and 6th; drop disp_req -> four writes drain on consecutive cycles, the pending write is then acked.
- swap_req pulse, then frame_start with FIFO empty -> swap_pending=1 until frame_start; front_sel 0->1 the next cycle; subsequent writes use address MSB 0.
- swap_req, then frame_start with fifo_level=3 and disp_req=1 for 2 cycles -> wr_ack=0 throughout DRAIN; front_sel toggles only after the 3rd write commits.
- Assert reset while fifo_level=2 and a read is in flight -> next cycle disp_valid=0, fifo_level=0, front_sel=0, mem_we=0.
